// File: rtl/rvvi_retire_serializer.sv
// Captures up to NHART*RETIRE retirement records per cycle into a FIFO and replays them
// one per cycle in retirement order, tagged with a global sequence number.
module rvvi_retire_serializer #(
    parameter int unsigned NHART  = 1,
    parameter int unsigned RETIRE = 1,
    parameter int unsigned ILEN   = 32,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SEQW   = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NHART*RETIRE-1:0]        in_valid,
    input  logic [NHART*RETIRE*ILEN-1:0]   in_insn,
    input  logic [NHART*RETIRE*XLEN-1:0]   in_pc,
    input  logic [NHART*RETIRE-1:0]        in_trap,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NHART):0]         out_hart,
    output logic [$clog2(RETIRE):0]        out_slot,
    output logic [ILEN-1:0]                out_insn,
    output logic [XLEN-1:0]                out_pc,
    output logic                           out_trap,
    output logic [SEQW-1:0]                out_seq,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow,
    output logic [15:0]                    drop_cnt
);

    localparam int unsigned NSLOT = NHART * RETIRE;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned HW    = $clog2(NHART) + 1;
    localparam int unsigned SW    = $clog2(RETIRE) + 1;

    typedef struct packed {
        logic [HW-1:0]   hart;
        logic [SW-1:0]   slot;
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic [SEQW-1:0] seq;
    } rec_t;

    rec_t            r_mem [DEPTH];
    rec_t            r_hold;
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic [SEQW-1:0] r_seq;
    logic            r_overflow;
    logic [15:0]     r_drop;

    rec_t            w_rec  [NSLOT];
    logic [CW-1:0]   w_rank [NSLOT];
    logic [CW-1:0]   w_n;
    logic [CW-1:0]   w_free;
    logic [CW-1:0]   w_acc;
    logic [CW-1:0]   w_drop;
    logic [16:0]     w_drop_sum;
    logic            w_pop;
    rec_t            w_head;

    // Rank each valid slot by prefix popcount; seq is assigned even to slots that get dropped.
    always_comb begin
        w_n = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            w_rank[i]     = w_n;
            w_rec[i].hart = HW'(i / RETIRE);
            w_rec[i].slot = SW'(i % RETIRE);
            w_rec[i].insn = in_insn[i*ILEN +: ILEN];
            w_rec[i].pc   = in_pc[i*XLEN +: XLEN];
            w_rec[i].trap = in_trap[i];
            w_rec[i].seq  = r_seq + SEQW'(w_n);
            if (in_valid[i]) begin
                w_n = w_n + 1'b1;
            end
        end
    end

    // Free space ignores this cycle's pop so out_ready never reaches the enqueue path.
    always_comb begin
        w_free     = CW'(DEPTH) - r_count;
        w_acc      = (w_n > w_free) ? w_free : w_n;
        w_drop     = w_n - w_acc;
        w_drop_sum = {1'b0, r_drop} + 17'(w_drop);
        w_pop      = (r_count != '0) && out_ready;
        w_head     = (r_count != '0) ? r_mem[r_rd] : r_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_hold     <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (in_valid[i] && (w_rank[i] < w_free)) begin
                    r_mem[r_wr + w_rank[i][PW-1:0]] <= w_rec[i];
                end
            end
            if (w_pop) begin
                r_hold <= r_mem[r_rd];
            end
            r_wr    <= r_wr + w_acc[PW-1:0];
            r_rd    <= r_rd + PW'(w_pop);
            r_count <= r_count + w_acc - CW'(w_pop);
            r_seq   <= r_seq + SEQW'(w_n);
            if (w_drop != '0) begin
                r_overflow <= 1'b1;
                r_drop     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_hart  = w_head.hart;
    assign out_slot  = w_head.slot;
    assign out_insn  = w_head.insn;
    assign out_pc    = w_head.pc;
    assign out_trap  = w_head.trap;
    assign out_seq   = w_head.seq;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// Scoreboard bench: a single-slot instance and a 2-hart x 2-slot, depth-4 instance.
module tb_rvvi_retire_serializer;

    typedef struct packed {
        logic [31:0] hart;
        logic [31:0] slot;
        logic [31:0] insn;
        logic [63:0] pc;
        logic        trap;
        logic [31:0] seq;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: NHART=1, RETIRE=1, DEPTH=16
    logic        a_valid, a_trap, a_out_valid, a_out_ready, a_out_trap, a_overflow;
    logic [31:0] a_insn, a_out_insn, a_out_seq;
    logic [63:0] a_pc, a_out_pc;
    logic [0:0]  a_out_hart, a_out_slot;
    logic [4:0]  a_count;
    logic [15:0] a_drop;

    // Instance B: NHART=2, RETIRE=2, DEPTH=4
    logic [3:0]   b_valid, b_trap;
    logic [127:0] b_insn;
    logic [255:0] b_pc;
    logic         b_out_valid, b_out_ready, b_out_trap, b_overflow;
    logic [1:0]   b_out_hart, b_out_slot;
    logic [31:0]  b_out_insn, b_out_seq;
    logic [63:0]  b_out_pc;
    logic [2:0]   b_count;
    logic [15:0]  b_drop;

    rvvi_retire_serializer #(
        .NHART(1), .RETIRE(1), .ILEN(32), .XLEN(64), .DEPTH(16), .SEQW(32)
    ) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_insn(a_insn), .in_pc(a_pc),
        .in_trap(a_trap), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_hart(a_out_hart), .out_slot(a_out_slot), .out_insn(a_out_insn),
        .out_pc(a_out_pc), .out_trap(a_out_trap), .out_seq(a_out_seq), .count(a_count),
        .overflow(a_overflow), .drop_cnt(a_drop)
    );

    rvvi_retire_serializer #(
        .NHART(2), .RETIRE(2), .ILEN(32), .XLEN(64), .DEPTH(4), .SEQW(32)
    ) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_insn(b_insn), .in_pc(b_pc),
        .in_trap(b_trap), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_hart(b_out_hart), .out_slot(b_out_slot), .out_insn(b_out_insn),
        .out_pc(b_out_pc), .out_trap(b_out_trap), .out_seq(b_out_seq), .count(b_count),
        .overflow(b_overflow), .drop_cnt(b_drop)
    );

    int   n_pass = 0;
    int   n_total = 0;
    rec_t qa [$];
    rec_t qb [$];
    rec_t ma_act, ma_exp, mb_act, mb_exp, last_b;
    int   uid = 0;
    int   b_seq = 0;

    // Scoreboard: every handshake is compared against the oldest expected record.
    always @(negedge clk) begin
        if (!reset && a_out_valid && a_out_ready) begin
            ma_act = '{hart: 32'(a_out_hart), slot: 32'(a_out_slot), insn: a_out_insn,
                       pc: a_out_pc, trap: a_out_trap, seq: a_out_seq};
            n_total++;
            if (qa.size() == 0) begin
                $display("FAIL a_record: got %h, expected none", ma_act);
            end else begin
                ma_exp = qa.pop_front();
                if (ma_act !== ma_exp) $display("FAIL a_record: got %h, expected %h", ma_act, ma_exp);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_out_valid && b_out_ready) begin
            mb_act = '{hart: 32'(b_out_hart), slot: 32'(b_out_slot), insn: b_out_insn,
                       pc: b_out_pc, trap: b_out_trap, seq: b_out_seq};
            n_total++;
            if (qb.size() == 0) begin
                $display("FAIL b_record: got %h, expected none", mb_act);
            end else begin
                mb_exp = qb.pop_front();
                if (mb_act !== mb_exp) $display("FAIL b_record: got %h, expected %h", mb_act, mb_exp);
                else n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        reset = 1'b1;
        a_valid = 1'b0; b_valid = '0; a_out_ready = 1'b0; b_out_ready = 1'b0;
        qa.delete(); qb.delete(); b_seq = 0;
        step();
        reset = 1'b0;
    endtask

    // Drives one cycle on instance B; the first `accept` valid slots are expected out.
    task automatic drive_b(input logic [3:0] v, input int accept);
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            uid++;
            b_insn[i*32 +: 32] = 32'h0000_0013 | 32'(uid << 7);
            b_pc[i*64 +: 64]   = 64'h8000_0000 + 64'(uid * 4);
            b_trap[i]          = (uid % 5 == 0);
            if (v[i]) begin
                if (k < accept) begin
                    qb.push_back('{hart: 32'(i / 2), slot: 32'(i % 2),
                                   insn: b_insn[i*32 +: 32], pc: b_pc[i*64 +: 64],
                                   trap: b_trap[i], seq: 32'(b_seq + k)});
                end
                k++;
            end
        end
        b_seq += k;
        b_valid = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_valid = 1'b0; a_insn = '0; a_pc = '0; a_trap = 1'b0; a_out_ready = 1'b0;
        b_valid = '0; b_insn = '0; b_pc = '0; b_trap = '0; b_out_ready = 1'b0;
        #12;
        n_total++;
        if ({a_out_valid, a_count, a_overflow, a_drop, a_out_seq, a_out_insn} !== '0)
            $display("FAIL reset_a: got valid=%b count=%0d ovf=%b drop=%0d seq=%0d insn=%h, expected all 0",
                     a_out_valid, a_count, a_overflow, a_drop, a_out_seq, a_out_insn);
        else n_pass++;
        n_total++;
        if ({b_out_valid, b_count, b_overflow, b_drop, b_out_seq, b_out_pc, b_out_hart} !== '0)
            $display("FAIL reset_b: got valid=%b count=%0d ovf=%b drop=%0d seq=%0d pc=%h, expected all 0",
                     b_out_valid, b_count, b_overflow, b_drop, b_out_seq, b_out_pc);
        else n_pass++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_in_order();
        apply_reset();
        a_out_ready = 1'b1;
        a_valid = 1'b1; a_insn = 32'h0000_0013; a_pc = 64'h8000_0000; a_trap = 1'b0;
        qa.push_back('{hart: 0, slot: 0, insn: a_insn, pc: a_pc, trap: a_trap, seq: 0});
        @(negedge clk);
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL no_bypass: got out_valid=%b, expected 0", a_out_valid);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) begin
                a_insn = 32'h0000_0013 + 32'((i + 1) << 8);
                a_pc   = 64'h8000_0000 + 64'((i + 1) * 4);
                a_trap = (i == 2);
                qa.push_back('{hart: 0, slot: 0, insn: a_insn, pc: a_pc, trap: a_trap,
                               seq: 32'(i + 1)});
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
            n_total++;
            if ({a_out_valid, a_out_seq, a_count} !== {1'b1, 32'(i), 5'd1})
                $display("FAIL single_latency: got valid=%b seq=%0d count=%0d, expected 1 %0d 1",
                         a_out_valid, a_out_seq, a_count, i);
            else n_pass++;
        end
        step();
        @(negedge clk);
        n_total++;
        if (a_out_valid !== 1'b0 || qa.size() != 0)
            $display("FAIL single_drain: got valid=%b pending=%0d, expected 0 0", a_out_valid, qa.size());
        else n_pass++;
    endtask

    task automatic test_multi_slot();
        apply_reset();
        b_out_ready = 1'b1;
        drive_b(4'b1011, 4);
        step();
        drive_b(4'b0100, 4);
        @(negedge clk);
        n_total++;
        if ({b_count, b_out_hart, b_out_slot, b_out_seq} !== {3'd3, 2'd0, 2'd0, 32'd0})
            $display("FAIL multi_head: got count=%0d h=%0d s=%0d seq=%0d, expected 3 0 0 0",
                     b_count, b_out_hart, b_out_slot, b_out_seq);
        else n_pass++;
        step();
        b_valid = '0;
        repeat (8) step();
        @(negedge clk);
        n_total++;
        if (qb.size() != 0 || b_out_valid !== 1'b0 || b_drop !== 16'd0)
            $display("FAIL multi_drain: got pending=%0d valid=%b drop=%0d, expected 0 0 0",
                     qb.size(), b_out_valid, b_drop);
        else n_pass++;
    endtask

    task automatic test_overflow();
        apply_reset();
        drive_b(4'b1111, 4);
        step();
        drive_b(4'b1111, 0);
        @(negedge clk);
        n_total++;
        if ({b_count, b_overflow} !== {3'd4, 1'b0})
            $display("FAIL fill: got count=%0d ovf=%b, expected 4 0", b_count, b_overflow);
        else n_pass++;
        step();
        b_valid = '0;
        @(negedge clk);
        n_total++;
        if ({b_count, b_overflow, b_drop} !== {3'd4, 1'b1, 16'd4})
            $display("FAIL overflow: got count=%0d ovf=%b drop=%0d, expected 4 1 4",
                     b_count, b_overflow, b_drop);
        else n_pass++;
        step();
        b_out_ready = 1'b1;
        repeat (6) step();
        drive_b(4'b0001, 1);
        step();
        b_valid = '0;
        repeat (4) step();
        @(negedge clk);
        n_total++;
        if (qb.size() != 0 || b_overflow !== 1'b1 || b_drop !== 16'd4)
            $display("FAIL overflow_after: got pending=%0d ovf=%b drop=%0d, expected 0 1 4",
                     qb.size(), b_overflow, b_drop);
        else n_pass++;
    endtask

    task automatic test_full_no_credit();
        apply_reset();
        drive_b(4'b1111, 4);
        step();
        b_out_ready = 1'b1;
        drive_b(4'b0001, 0);
        step();
        b_valid = '0;
        @(negedge clk);
        n_total++;
        if ({b_count, b_overflow, b_drop} !== {3'd3, 1'b1, 16'd1})
            $display("FAIL no_credit: got count=%0d ovf=%b drop=%0d, expected 3 1 1",
                     b_count, b_overflow, b_drop);
        else n_pass++;
        repeat (6) step();
        @(negedge clk);
        n_total++;
        if (qb.size() != 0 || b_count !== 3'd0)
            $display("FAIL no_credit_drain: got pending=%0d count=%0d, expected 0 0", qb.size(), b_count);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [11:0] pat = 12'b1110_1101_1010;
        apply_reset();
        drive_b(4'b0111, 4);
        last_b = qb[2];
        step();
        b_valid = '0;
        for (int c = 0; c < 12; c++) begin
            b_out_ready = pat[c];
            @(negedge clk);
            if (b_out_valid && !b_out_ready && qb.size() != 0) begin
                n_total++;
                if (b_out_seq !== qb[0].seq || b_out_insn !== qb[0].insn)
                    $display("FAIL stall_hold: got seq=%0d insn=%h, expected seq=%0d insn=%h",
                             b_out_seq, b_out_insn, qb[0].seq, qb[0].insn);
                else n_pass++;
            end
            step();
        end
        @(negedge clk);
        n_total++;
        if (qb.size() != 0 || b_out_valid !== 1'b0 || b_out_seq !== last_b.seq ||
            b_out_insn !== last_b.insn)
            $display("FAIL idle_hold: got pending=%0d valid=%b seq=%0d insn=%h, expected 0 0 %0d %h",
                     qb.size(), b_out_valid, b_out_seq, b_out_insn, last_b.seq, last_b.insn);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_b(4'b1111, 4);
        step();
        drive_b(4'b1111, 0);
        step();
        b_valid = '0;
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({b_count, b_overflow} !== {3'd3, 1'b1})
            $display("FAIL pre_reset: got count=%0d ovf=%b, expected 3 1", b_count, b_overflow);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if ({b_out_valid, b_count, b_overflow, b_drop, b_out_seq} !== '0)
            $display("FAIL async_reset: got valid=%b count=%0d ovf=%b drop=%0d seq=%0d, expected all 0",
                     b_out_valid, b_count, b_overflow, b_drop, b_out_seq);
        else n_pass++;
        qb.delete();
        b_seq = 0;
        step();
        reset = 1'b0;
        b_out_ready = 1'b1;
        drive_b(4'b0001, 1);
        step();
        b_valid = '0;
        repeat (3) step();
        @(negedge clk);
        n_total++;
        if (qb.size() != 0) $display("FAIL post_reset: got pending=%0d, expected 0", qb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_multi_slot();
        test_overflow();
        test_full_no_credit();
        test_back_pressure();
        test_async_reset();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
